// File: rtl/operand_forward_stage_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
//   Shared types and constants for the ID/EX operand forwarding stage.
//   fwd_sel_t encodes which pipeline stage supplied an operand; the state
//   enum tracks whether decode is currently being held by a hazard.
// ---------------------------------------------------------------------------
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_t;

  localparam int PERF_W = 16;

endpackage

// File: rtl/operand_forward_stage_if.sv
// ---------------------------------------------------------------------------
// operand_forward_stage_if
//   Bundles the decode, bypass-network and EX handshake signals of the
//   operand forwarding stage.
//   master : pipeline side, drives decode/bypass/EX-control inputs and
//            observes id_stall and the ID/EX register outputs.
//   slave  : the forwarding stage itself.
// ---------------------------------------------------------------------------
interface operand_forward_stage_if #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2
);

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [NUM_SRC*DATA_W-1:0]   id_src_data;
  logic                        ex_wr_en;
  logic [REG_AW-1:0]           ex_wr_addr;
  logic                        ex_is_load;
  logic [DATA_W-1:0]           ex_alu_result;
  logic                        mem_wr_en;
  logic [REG_AW-1:0]           mem_wr_addr;
  logic                        mem_res_valid;
  logic [DATA_W-1:0]           mem_result;
  logic                        wb_wr_en;
  logic [REG_AW-1:0]           wb_wr_addr;
  logic [DATA_W-1:0]           wb_result;
  logic                        ex_ready;
  logic                        ex_flush;
  logic                        id_stall;
  logic                        ex_valid;
  logic [NUM_SRC*DATA_W-1:0]   ex_src_data;
  logic [NUM_SRC*2-1:0]        ex_fwd_sel;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_src_data,
    output ex_wr_en, ex_wr_addr, ex_is_load, ex_alu_result,
    output mem_wr_en, mem_wr_addr, mem_res_valid, mem_result,
    output wb_wr_en, wb_wr_addr, wb_result,
    output ex_ready, ex_flush,
    input  id_stall, ex_valid, ex_src_data, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_src_data,
    input  ex_wr_en, ex_wr_addr, ex_is_load, ex_alu_result,
    input  mem_wr_en, mem_wr_addr, mem_res_valid, mem_result,
    input  wb_wr_en, wb_wr_addr, wb_result,
    input  ex_ready, ex_flush,
    output id_stall, ex_valid, ex_src_data, ex_fwd_sel
  );

endinterface

// File: rtl/operand_forward_stage_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Combinational bypass selection for a single source operand.
//   Picks the newest producer (EX > MEM > WB > register file) and flags a
//   hazard when the winning producer cannot deliver its value yet.
//   Ports:
//     src_addr/src_used/rf_data : operand address, use flag, regfile data
//     ex_* / mem_* / wb_*       : producer write ports of later stages
//     data / sel / hazard       : selected value, its source, hazard flag
// ---------------------------------------------------------------------------
module fwd_select
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int R0_ZERO = 0
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic              mem_res_valid,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output fwd_sel_t          sel,
  output logic              hazard
);

  logic is_r0;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign is_r0   = (R0_ZERO != 0) && (src_addr == '0);
  assign ex_hit  = ex_wr_en  && (ex_wr_addr  == src_addr);
  assign mem_hit = mem_wr_en && (mem_wr_addr == src_addr);
  assign wb_hit  = wb_wr_en  && (wb_wr_addr  == src_addr);

  // Priority bypass mux. A hard-wired zero register bypasses everything.
  // A load in EX has no result yet; a MEM producer only stalls when it is
  // the winning source and its result is still pending.
  always_comb begin
    data   = rf_data;
    sel    = FWD_RF;
    hazard = 1'b0;
    if (is_r0) begin
      data = '0;
    end else if (ex_hit) begin
      data   = ex_alu_result;
      sel    = FWD_EX;
      hazard = src_used & ex_is_load;
    end else if (mem_hit) begin
      data   = mem_result;
      sel    = FWD_MEM;
      hazard = src_used & ~mem_res_valid;
    end else if (wb_hit) begin
      data = wb_result;
      sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_forward_stage.sv
// ---------------------------------------------------------------------------
// operand_forward_stage
//   ID/EX operand stage with multi-source forwarding. Selects the newest
//   value for each source operand, captures it into the ID/EX register,
//   inserts bubbles on load-use / pending-result hazards and honours EX
//   back-pressure and flush.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : operand_forward_stage_if.slave (decode, bypass, EX side)
//     perf_stall_cnt, perf_fwd_cnt : optional saturating event counters
//   Build option: define FWD_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module operand_forward_stage
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int R0_ZERO = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  operand_forward_stage_if.slave    bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]         perf_stall_cnt,
  output logic [PERF_W-1:0]         perf_fwd_cnt
`endif
);

  logic [NUM_SRC*DATA_W-1:0] sel_data;
  logic [NUM_SRC*2-1:0]      sel_code;
  logic [NUM_SRC-1:0]        src_hazard;
  logic                      hz;
  logic                      held;
  logic                      valid_q;
  logic [NUM_SRC*DATA_W-1:0] data_q;
  logic [NUM_SRC*2-1:0]      sel_q;
  fwd_state_t                state;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .R0_ZERO (R0_ZERO)
    ) u_sel (
      .src_addr      (bus.id_src_addr[i*REG_AW +: REG_AW]),
      .src_used      (bus.id_src_used[i]),
      .rf_data       (bus.id_src_data[i*DATA_W +: DATA_W]),
      .ex_wr_en      (bus.ex_wr_en),
      .ex_wr_addr    (bus.ex_wr_addr),
      .ex_is_load    (bus.ex_is_load),
      .ex_alu_result (bus.ex_alu_result),
      .mem_wr_en     (bus.mem_wr_en),
      .mem_wr_addr   (bus.mem_wr_addr),
      .mem_res_valid (bus.mem_res_valid),
      .mem_result    (bus.mem_result),
      .wb_wr_en      (bus.wb_wr_en),
      .wb_wr_addr    (bus.wb_wr_addr),
      .wb_result     (bus.wb_result),
      .data          (sel_data[i*DATA_W +: DATA_W]),
      .sel           (sel_code[i*2 +: 2]),
      .hazard        (src_hazard[i])
    );
  end

  assign hz   = bus.id_valid & (|src_hazard);
  assign held = valid_q & ~bus.ex_ready;

  // Stall is forced low during reset so decode is never frozen by stale
  // bypass inputs while the pipeline is being reset.
  assign bus.id_stall    = rst_n & (hz | held);
  assign bus.ex_valid    = valid_q;
  assign bus.ex_src_data = data_q;
  assign bus.ex_fwd_sel  = sel_q;

  // ID/EX register: flush beats everything, back-pressure holds the whole
  // register, a hazard turns the slot into a bubble, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (bus.ex_flush) begin
      valid_q <= 1'b0;
    end else if (!held) begin
      if (hz) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.id_valid;
        data_q  <= sel_data;
        sel_q   <= sel_code;
      end
    end
  end

  // Hazard tracking state; entering STALL only when the bubble is actually
  // being inserted, leaving as soon as the hazard disappears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (hz && !held) state <= STALL;
        STALL:   if (!hz) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic capture_fwd;

  assign capture_fwd = ~bus.ex_flush & ~held & ~hz & bus.id_valid & (|sel_code);

  // Saturating event counters: hazard cycles and captured instructions
  // that took at least one operand from the bypass network.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if ((hz || state == STALL && hz) && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
      if (capture_fwd && perf_fwd_cnt != '1) begin
        perf_fwd_cnt <= perf_fwd_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
